// File: rtl/cpu_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer_if
//  Purpose  : Instruction-memory fetch handshake between the CPU sequencer and
//             the instruction memory.
//  Signals  : IMEM_READ     - fetch request (sequencer -> memory)
//             IMEM_ADDR     - 32-bit fetch address (sequencer -> memory)
//             IMEM_RDATA    - 32-bit instruction word (memory -> sequencer)
//             IMEM_BUSYWAIT - memory stall (memory -> sequencer)
//  Modports : master = sequencer side, slave = memory side
//  Revision : 1.0 - initial release
// ============================================================================
interface cpu_sequencer_if;
    logic        IMEM_READ;
    logic [31:0] IMEM_ADDR;
    logic [31:0] IMEM_RDATA;
    logic        IMEM_BUSYWAIT;

    modport master (
        output IMEM_READ,
        output IMEM_ADDR,
        input  IMEM_RDATA,
        input  IMEM_BUSYWAIT
    );

    modport slave (
        input  IMEM_READ,
        input  IMEM_ADDR,
        output IMEM_RDATA,
        output IMEM_BUSYWAIT
    );
endinterface
`default_nettype wire

// File: rtl/cpu_sequencer.sv
`default_nettype none
// ============================================================================
//  Module   : cpu_sequencer
//  Purpose  : Multi-cycle control sequencer for the 8-bit CPU datapath.
//             Fetches 32-bit instructions over the imem handshake, latches
//             them into IR, decodes the opcode into datapath control lines
//             and owns the PC (sequential, jump, branch-if-equal).
//  Ports    : CLK, RESET      - clock, synchronous active-high reset
//             imem (master)   - instruction fetch handshake
//             ALU_ZERO        - ALU result is zero (beq condition)
//             PC              - program counter
//             ALUOP, MUX_NEG, MUX_IMM, WRITEENABLE - datapath controls
//             WRITEREG, READREG1, READREG2, IMMEDIATE - IR fields
//             ILLEGAL         - sticky undefined-opcode flag
//  Revision : 1.0 - initial release
// ============================================================================
module cpu_sequencer #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  wire logic        CLK,
    input  wire logic        RESET,
    cpu_sequencer_if.master  imem,
    input  wire logic        ALU_ZERO,
    output logic [31:0]      PC,
    output logic [2:0]       ALUOP,
    output logic             MUX_NEG,
    output logic             MUX_IMM,
    output logic             WRITEENABLE,
    output logic [2:0]       WRITEREG,
    output logic [2:0]       READREG1,
    output logic [2:0]       READREG2,
    output logic [7:0]       IMMEDIATE,
    output logic             ILLEGAL
);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_FETCH  = 3'd1;
    localparam logic [2:0] S_DECODE = 3'd2;
    localparam logic [2:0] S_EXEC   = 3'd3;
    localparam logic [2:0] S_WB     = 3'd4;
    localparam logic [2:0] S_HALT   = 3'd5;

    localparam logic [7:0] c_OP_J   = 8'h06;
    localparam logic [7:0] c_OP_BEQ = 8'h07;

    logic [2:0]  r_state;
    logic [2:0]  w_next_state;
    logic [31:0] r_pc;
    logic [31:0] r_ir;
    logic        r_illegal;
    logic        r_taken;

    logic [7:0]  w_opcode;
    logic        w_op_illegal;
    logic [31:0] w_pc_seq;
    logic [31:0] w_offset;
    logic        w_redirect;
    logic [31:0] w_pc_next;

    logic        w_imem_read;
    logic        w_we;
    logic [2:0]  w_aluop;
    logic        w_neg;
    logic        w_imm;

    // IR[15:11] carries no field for this instruction set.
    logic        w_unused_ir;
    assign w_unused_ir = ^r_ir[15:11];

    assign w_opcode     = r_ir[31:24];
    assign w_op_illegal = (w_opcode > c_OP_BEQ);

    // Branch/jump target is relative to PC+4; offset is in words.
    assign w_pc_seq   = r_pc + 32'd4;
    assign w_offset   = {{22{r_ir[23]}}, r_ir[23:16], 2'b00};
    assign w_redirect = (w_opcode == c_OP_J) || ((w_opcode == c_OP_BEQ) && r_taken);
    assign w_pc_next  = w_redirect ? (w_pc_seq + w_offset) : w_pc_seq;

    // State and datapath registers
    always_ff @(posedge CLK) begin
        if (RESET) begin
            r_state   <= S_IDLE;
            r_pc      <= RESET_PC;
            r_ir      <= 32'h0000_0000;
            r_illegal <= 1'b0;
            r_taken   <= 1'b0;
        end else begin
            r_state <= w_next_state;
            if ((r_state == S_FETCH) && !imem.IMEM_BUSYWAIT) begin
                r_ir <= imem.IMEM_RDATA;
            end
            if ((r_state == S_DECODE) && w_op_illegal) begin
                r_illegal <= 1'b1;
            end
            // The ALU has settled by the end of EXEC; capture the compare.
            if (r_state == S_EXEC) begin
                r_taken <= ALU_ZERO;
            end
            if (r_state == S_WB) begin
                r_pc <= w_pc_next;
            end
        end
    end

    // Next-state logic
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_IDLE:   w_next_state = S_FETCH;
            S_FETCH:  w_next_state = imem.IMEM_BUSYWAIT ? S_FETCH : S_DECODE;
            S_DECODE: w_next_state = w_op_illegal ? S_HALT : S_EXEC;
            S_EXEC:   w_next_state = S_WB;
            S_WB:     w_next_state = S_FETCH;
            S_HALT:   w_next_state = S_HALT;
            default:  w_next_state = S_IDLE;
        endcase
    end

    // Output decode; controls are only live while IR holds a fetched word.
    always_comb begin
        w_imem_read = 1'b0;
        w_we        = 1'b0;
        w_aluop     = 3'b000;
        w_neg       = 1'b0;
        w_imm       = 1'b0;
        case (r_state)
            S_FETCH: w_imem_read = 1'b1;
            S_DECODE, S_EXEC, S_WB: begin
                case (w_opcode)
                    8'h00: w_imm   = 1'b1;
                    8'h02: w_aluop = 3'b001;
                    8'h03: begin
                        w_aluop = 3'b001;
                        w_neg   = 1'b1;
                    end
                    8'h04: w_aluop = 3'b010;
                    8'h05: w_aluop = 3'b011;
                    8'h07: begin
                        w_aluop = 3'b001;
                        w_neg   = 1'b1;
                    end
                    default: w_aluop = 3'b000;
                endcase
                if ((r_state == S_WB) && (w_opcode <= 8'h05)) begin
                    w_we = 1'b1;
                end
            end
            default: w_imem_read = 1'b0;
        endcase
    end

    assign imem.IMEM_READ = w_imem_read;
    assign imem.IMEM_ADDR = r_pc;
    assign PC             = r_pc;
    assign ALUOP          = w_aluop;
    assign MUX_NEG        = w_neg;
    assign MUX_IMM        = w_imm;
    assign WRITEENABLE    = w_we;
    assign WRITEREG       = r_ir[18:16];
    assign READREG1       = r_ir[10:8];
    assign READREG2       = r_ir[2:0];
    assign IMMEDIATE      = r_ir[7:0];
    assign ILLEGAL        = r_illegal;

endmodule
`default_nettype wire

// File: doc/cpu_sequencer.md
Name: cpu_sequencer

Overview:
Multi-cycle control sequencer for the 8-bit CPU datapath (register file, ALU, negate mux, immediate mux). It fetches 32-bit instructions from instruction memory using a READ/BUSYWAIT handshake and latches each into an instruction register (IR). It then decodes the opcode, drives the datapath control lines per state, and owns the PC, including jump and branch-if-equal. It replaces the single-cycle decode and PC logic in the cpu top level.

Parameters:
RESET_PC, 32'h0000_0000, PC value loaded on reset

Ports:
CLK  in  1  clock; all state updates on posedge
RESET  in  1  synchronous, active-high reset
IMEM_READ  out  1  instruction fetch request
IMEM_ADDR  out  32  fetch address; equals PC
IMEM_RDATA  in  32  instruction word; valid when IMEM_READ=1 and IMEM_BUSYWAIT=0
IMEM_BUSYWAIT  in  1  memory stall; fetch completes on the first edge where it is 0
ALU_ZERO  in  1  ALU result == 0
PC  out  32  program counter (register)
ALUOP  out  3  000 fwd, 001 add, 010 and, 011 or
MUX_NEG  out  1  select negated operand 2
MUX_IMM  out  1  select IMMEDIATE as operand 2
WRITEENABLE  out  1  register file write strobe
WRITEREG  out  3  IR[18:16]
READREG1  out  3  IR[10:8]
READREG2  out  3  IR[2:0]
IMMEDIATE  out  8  IR[7:0]
ILLEGAL  out  1  sticky; set on an undefined opcode

Behaviour:
- States: IDLE, FETCH, DECODE, EXEC, WB, HALT. Encoding is free.
- Reset: if RESET=1 at a posedge, next state is IDLE, PC=RESET_PC, IR=0, ILLEGAL=0. Reset wins over every other event, including mid-fetch and during WB.
- Outputs during IDLE and HALT: IMEM_READ=0, WRITEENABLE=0.
- IDLE -> FETCH unconditionally.
- FETCH: IMEM_READ=1, IMEM_ADDR=PC.
  - BUSYWAIT=1: stay in FETCH; IR and PC unchanged.
  - BUSYWAIT=0: IR<=IMEM_RDATA, go to DECODE.
  - A zero-wait fetch takes exactly 1 cycle.
- DECODE: 1 cycle for register-file read. If IR[31:24] > 8'h07, set ILLEGAL=1 and go to HALT; PC is not advanced.
- EXEC: 1 cycle for the ALU to settle. For beq, ALU_ZERO is sampled at the end of this cycle into a taken flag.
- WB: 1 cycle.
  - WRITEENABLE=1 only for opcodes 0-5.
  - PC<=PC+4, or PC+4+(sext(IR[23:16])<<2) for j, or for beq when taken.
  - Next state is FETCH.
- Control decode from IR (held stable in DECODE, EXEC and WB; all zero elsewhere):
  - 00 loadi: ALUOP=000, MUX_IMM=1
  - 01 mov: ALUOP=000
  - 02 add: ALUOP=001
  - 03 sub: ALUOP=001, MUX_NEG=1
  - 04 and: ALUOP=010
  - 05 or: ALUOP=011
  - 06 j: no write, unconditional jump
  - 07 beq: ALUOP=001, MUX_NEG=1, no write; taken iff ALU_ZERO
- Latency: 4 cycles per instruction plus N BUSYWAIT cycles.
- Arithmetic: PC wraps modulo 2^32. Branch offsets are signed (-128..+127 words) and are relative to PC+4.
- HALT: absorbing state; the only exit is RESET. ILLEGAL stays 1 and PC holds the address of the illegal instruction.
- Control outputs are combinational from state and IR. PC, IR, state and ILLEGAL are registers.

Test Plan:
- Reset then zero-wait memory with loadi r1,#5 at 0x0 -> IMEM_READ rises 1 cycle after RESET falls; WRITEENABLE pulses 1 cycle in WB with ALUOP=000, MUX_IMM=1, WRITEREG=1, IMMEDIATE=5; PC becomes 4 at the end of WB.
- Fetch with BUSYWAIT held high for 3 cycles -> FETCH lasts 4 cycles, IMEM_ADDR stays at PC, IR updates only on the BUSYWAIT=0 edge; the instruction takes 7 cycles total.
- sub r3,r1,r2 (IR=0x03030102) -> ALUOP=001, MUX_NEG=1, READREG1=1, READREG2=2, WRITEREG=3 through DECODE/EXEC/WB.
- beq with offset 0xFE at PC=0x10: ALU_ZERO=1 -> PC=0x0C; ALU_ZERO=0 -> PC=0x14; WRITEENABLE stays 0 in both cases.
- j with offset 0x01 at PC=0xFFFFFFF8 -> PC wraps to 0x00000000.
- Opcode 0x09 at PC=0x20 -> ILLEGAL=1, HALT, IMEM_READ=0, PC holds 0x20. RESET asserted mid-FETCH in a later run -> next cycle IDLE, PC=RESET_PC, ILLEGAL=0.
